// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-measurement controller.
package freq_meas_pkg;

    localparam int unsigned DEF_COUNT_WIDTH = 32;
    localparam int unsigned DEF_TMO_WIDTH   = 32;
    localparam int unsigned DEF_MIN_COUNT   = 1000000;
    localparam int unsigned DEF_MAX_NCYCLES = 65536;
    localparam int unsigned ARM_CLKS        = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DISCARD,
        MEASURE,
        RESULT
    } state_e;

endpackage

// File: rtl/freq_meas_timer.sv
// Saturating no-progress timer; expired flags the clock on which the count reaches limit.
module freq_meas_timer
    import freq_meas_pkg::*;
#(
    parameter int unsigned TMO_WIDTH = DEF_TMO_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TMO_WIDTH-1:0] limit,
    output logic                 expired
);

    logic [TMO_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + TMO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires one clock early so the transition edge is the one where the count hits limit.
    assign expired = enable && (limit != '0) && (count_q >= limit - TMO_WIDTH'(1));

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: arm counter, drop partial window, capture/timeout, hand off result.
// Optional feature: FREQ_MEAS_AUTORANGE_EN enables Ncycles doubling/halving re-arms.
module freq_meas_ctrl
    import freq_meas_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned TMO_WIDTH   = DEF_TMO_WIDTH,
    parameter int unsigned MIN_COUNT   = DEF_MIN_COUNT,
    parameter int unsigned MAX_NCYCLES = DEF_MAX_NCYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [COUNT_WIDTH-1:0] ncycles_init,
    input  logic [TMO_WIDTH-1:0]   tmo_limit,
    input  logic [COUNT_WIDTH-1:0] cnt_value,
    input  logic                   cnt_done,
    output logic                   cnt_rst_n,
    output logic [COUNT_WIDTH-1:0] cnt_ncycles,
    output logic [COUNT_WIDTH-1:0] res_count,
    output logic [COUNT_WIDTH-1:0] res_ncycles,
    output logic                   res_timeout,
    output logic                   res_overrun,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [1:0]             arm_cnt_q, arm_cnt_d;
    logic                   cnt_rst_n_q, cnt_rst_n_d;
    logic [COUNT_WIDTH-1:0] cnt_ncycles_q, cnt_ncycles_d;
    logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic [COUNT_WIDTH-1:0] res_ncycles_q, res_ncycles_d;
    logic                   res_timeout_q, res_timeout_d;
    logic                   res_overrun_q, res_overrun_d;
    logic                   ovr_pend_q, ovr_pend_d;

    logic tmr_active, tmr_clear, tmo_expired;
    logic take_count, take_tmo, emit;

    assign tmr_active = (state_q == DISCARD) || (state_q == MEASURE);
    assign tmr_clear  = !tmr_active || cnt_done;

    freq_meas_timer #(
        .TMO_WIDTH(TMO_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_active),
        .limit  (tmo_limit),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = '0;
        cnt_ncycles_d = cnt_ncycles_q;
        res_count_d   = res_count_q;
        res_ncycles_d = res_ncycles_q;
        res_timeout_d = res_timeout_q;
        res_overrun_d = res_overrun_q;
        ovr_pend_d    = ovr_pend_q;
        take_count    = 1'b0;
        take_tmo      = 1'b0;
        emit          = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_ncycles_d = (ncycles_init == '0) ? COUNT_WIDTH'(1) : ncycles_init;
                        state_d       = ARM;
                    end
                end
                ARM: begin
                    if (arm_cnt_q == 2'(ARM_CLKS - 1)) begin
                        state_d = DISCARD;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 2'd1;
                    end
                end
                DISCARD: begin
                    if (cnt_done) begin
                        state_d = MEASURE;
                    end else if (tmo_expired) begin
                        take_tmo = 1'b1;
                    end
                end
                MEASURE: begin
                    if (cnt_done) begin
                        take_count = 1'b1;
                    end else if (tmo_expired) begin
                        take_tmo = 1'b1;
                    end
                end
                RESULT: begin
                    if (cnt_done) begin
                        ovr_pend_d = 1'b1;
                    end
                    if (res_ready) begin
                        state_d = continuous ? MEASURE : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef FREQ_MEAS_AUTORANGE_EN
        if (take_count && (cnt_value < COUNT_WIDTH'(MIN_COUNT))
                       && (cnt_ncycles_q < COUNT_WIDTH'(MAX_NCYCLES))) begin
            cnt_ncycles_d = cnt_ncycles_q << 1;
            state_d       = ARM;
        end else if (take_tmo && (cnt_ncycles_q > COUNT_WIDTH'(1))) begin
            cnt_ncycles_d = cnt_ncycles_q >> 1;
            state_d       = ARM;
        end else begin
            emit = take_count || take_tmo;
        end
`else
        emit = take_count || take_tmo;
`endif

        // Emitting a result consumes the pending overrun so it is reported exactly once.
        if (emit) begin
            state_d       = RESULT;
            res_count_d   = take_count ? cnt_value : '0;
            res_ncycles_d = cnt_ncycles_q;
            res_timeout_d = take_tmo;
            res_overrun_d = ovr_pend_q;
            ovr_pend_d    = 1'b0;
        end

        cnt_rst_n_d = (state_d != ARM);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            arm_cnt_q     <= '0;
            cnt_rst_n_q   <= 1'b0;
            cnt_ncycles_q <= COUNT_WIDTH'(1);
            res_count_q   <= '0;
            res_ncycles_q <= '0;
            res_timeout_q <= 1'b0;
            res_overrun_q <= 1'b0;
            ovr_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            cnt_rst_n_q   <= cnt_rst_n_d;
            cnt_ncycles_q <= cnt_ncycles_d;
            res_count_q   <= res_count_d;
            res_ncycles_q <= res_ncycles_d;
            res_timeout_q <= res_timeout_d;
            res_overrun_q <= res_overrun_d;
            ovr_pend_q    <= ovr_pend_d;
        end
    end

    assign cnt_rst_n   = cnt_rst_n_q;
    assign cnt_ncycles = cnt_ncycles_q;
    assign res_count   = res_count_q;
    assign res_ncycles = res_ncycles_q;
    assign res_timeout = res_timeout_q;
    assign res_overrun = res_overrun_q;
    assign res_valid   = (state_q == RESULT);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_freq_meas_ctrl;

    localparam int unsigned CW      = 32;
    localparam int unsigned TW      = 32;
    localparam longint      MIN_CNT = 1000000;
    localparam longint      MAX_NC  = 65536;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, continuous, cnt_done, res_ready;
    logic [CW-1:0] ncycles_init, cnt_value;
    logic [TW-1:0] tmo_limit;
    logic          cnt_rst_n, res_timeout, res_overrun, res_valid, busy;
    logic [CW-1:0] cnt_ncycles, res_count, res_ncycles;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    freq_meas_ctrl #(
        .COUNT_WIDTH(CW),
        .TMO_WIDTH  (TW),
        .MIN_COUNT  (1000000),
        .MAX_NCYCLES(65536)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .ncycles_init(ncycles_init),
        .tmo_limit   (tmo_limit),
        .cnt_value   (cnt_value),
        .cnt_done    (cnt_done),
        .cnt_rst_n   (cnt_rst_n),
        .cnt_ncycles (cnt_ncycles),
        .res_count   (res_count),
        .res_ncycles (res_ncycles),
        .res_timeout (res_timeout),
        .res_overrun (res_overrun),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase plus "clocks since last progress" and a countdown of arm clocks.
    typedef enum int {M_IDLE, M_ARM, M_DISCARD, M_MEASURE, M_RESULT} mphase_t;
    mphase_t m_phase = M_IDLE;
    bit      m_live  = 1'b0;
    longint  m_ncyc, m_cnt, m_rn, m_timer;
    bit      m_rtmo, m_rovr, m_ovr, m_crn;
    int      m_arm_left;

    task automatic m_emit(input longint cnt, input bit tmo);
        m_cnt   = cnt;
        m_rn    = m_ncyc;
        m_rtmo  = tmo;
        m_rovr  = m_ovr;
        m_ovr   = 1'b0;
        m_phase = M_RESULT;
    endtask

    task automatic m_rearm();
        m_phase    = M_ARM;
        m_arm_left = 2;
    endtask

    task automatic m_measured(input longint v);
`ifdef FREQ_MEAS_AUTORANGE_EN
        if (v < MIN_CNT && m_ncyc < MAX_NC) begin
            m_ncyc = m_ncyc * 2;
            m_rearm();
            return;
        end
`endif
        m_emit(v, 1'b0);
    endtask

    task automatic m_timed_out();
`ifdef FREQ_MEAS_AUTORANGE_EN
        if (m_ncyc > 1) begin
            m_ncyc = m_ncyc / 2;
            m_rearm();
            return;
        end
`endif
        m_emit(0, 1'b1);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_live  = 1'b1;
            m_phase = M_IDLE;
            m_ncyc  = 1;
            m_cnt   = 0;
            m_rn    = 0;
            m_rtmo  = 1'b0;
            m_rovr  = 1'b0;
            m_ovr   = 1'b0;
            m_timer = 0;
            m_crn   = 1'b0;
        end else begin
            if (stop) begin
                m_phase = M_IDLE;
            end else begin
                case (m_phase)
                    M_IDLE: if (start) begin
                        m_ncyc = (ncycles_init == 0) ? 1 : longint'(ncycles_init);
                        m_rearm();
                    end
                    M_ARM: begin
                        m_arm_left--;
                        if (m_arm_left == 0) begin
                            m_phase = M_DISCARD;
                            m_timer = 0;
                        end
                    end
                    M_DISCARD, M_MEASURE: begin
                        if (cnt_done) begin
                            m_timer = 0;
                            if (m_phase == M_DISCARD) m_phase = M_MEASURE;
                            else m_measured(longint'(cnt_value));
                        end else begin
                            m_timer++;
                            if (tmo_limit != 0 && m_timer >= longint'(tmo_limit)) m_timed_out();
                        end
                    end
                    M_RESULT: begin
                        if (cnt_done) m_ovr = 1'b1;
                        if (res_ready) begin
                            m_phase = continuous ? M_MEASURE : M_IDLE;
                            m_timer = 0;
                        end
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
            m_crn = (m_phase != M_ARM);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy",        busy,        m_phase != M_IDLE);
            chk("res_valid",   res_valid,   m_phase == M_RESULT);
            chk("cnt_rst_n",   cnt_rst_n,   m_crn);
            chk("cnt_ncycles", cnt_ncycles, m_ncyc);
            chk("res_count",   res_count,   m_cnt);
            chk("res_ncycles", res_ncycles, m_rn);
            chk("res_timeout", res_timeout, m_rtmo);
            chk("res_overrun", res_overrun, m_rovr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [CW-1:0] v);
        cnt_value = v;
        cnt_done  = 1'b1;
        tick();
        cnt_done  = 1'b0;
    endtask

    task automatic run_basic();
        tmo_limit    = '0;
        continuous   = 1'b0;
        res_ready    = 1'b0;
        ncycles_init = 32'd10;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("arm1_rst_n", cnt_rst_n, 0);
        chk("arm_ncyc", cnt_ncycles, 10);
        tick();
        chk("arm2_rst_n", cnt_rst_n, 0);
        tick();
        chk("discard_rst_n", cnt_rst_n, 1);
        chk("discard_busy", busy, 1);
        pulse(32'd1250);
        chk("dropped_no_valid", res_valid, 0);
        tick();
        tick();
        pulse(32'd12500);
        chk("basic_valid", res_valid, 1);
        chk("basic_count", res_count, 12500);
        chk("basic_ncyc", res_ncycles, 10);
        chk("basic_tmo", res_timeout, 0);
        repeat (3) tick();
        chk("basic_hold_valid", res_valid, 1);
        chk("basic_hold_count", res_count, 12500);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("basic_xfer_valid", res_valid, 0);
        chk("basic_xfer_busy", busy, 0);
    endtask

    task automatic into_measure();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pulse(32'd7);
    endtask

    initial begin
        int unsigned n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; cnt_done = 1'b0;
        res_ready = 1'b0; ncycles_init = '0; cnt_value = '0; tmo_limit = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_cnt_rst_n", cnt_rst_n, 0);
        chk("rst_ncyc", cnt_ncycles, 1);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", res_count, 0);
        rst = 1'b1;
        tick();
        tick();

        run_basic();

        // Timeout with no counter activity.
        tmo_limit = 32'd1000;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n = 0;
        for (int unsigned i = 1; i <= 2000; i++) begin
            tick();
            if (res_valid) begin
                n = i;
                break;
            end
        end
        chk("tmo_latency", n, 1000);
        chk("tmo_flag", res_timeout, 1);
        chk("tmo_count", res_count, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tmo_limit = '0;

        // Overrun while a continuous result waits.
        continuous = 1'b1;
        into_measure();
        pulse(32'd777);
        chk("ovr_first", res_overrun, 0);
        for (int unsigned i = 0; i < 50; i++) begin
            if (i == 10) cnt_done = 1'b1;
            tick();
            cnt_done = 1'b0;
        end
        chk("ovr_wait_valid", res_valid, 1);
        chk("ovr_wait_count", res_count, 777);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        pulse(32'd888);
        chk("ovr_set", res_overrun, 1);
        chk("ovr_set_count", res_count, 888);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        pulse(32'd999);
        chk("ovr_cleared", res_overrun, 0);
        continuous = 1'b0;
        res_ready  = 1'b1;
        tick();
        res_ready = 1'b0;

        // Stop beats a same-cycle cnt_done.
        into_measure();
        stop = 1'b1;
        pulse(32'd4242);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_valid", res_valid, 0);

        // Reset while holding a result.
        into_measure();
        pulse(32'd4321);
        chk("pre_rst_valid", res_valid, 1);
        rst = 1'b0;
        tick();
        chk("midrst_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rst_n", cnt_rst_n, 0);
        chk("midrst_ncyc", cnt_ncycles, 1);
        chk("midrst_count", res_count, 0);
        rst = 1'b1;
        tick();
        run_basic();

`ifdef FREQ_MEAS_AUTORANGE_EN
        ncycles_init = 32'd1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            tick();
            chk("ar_ncyc", cnt_ncycles, 64'd1 << k);
            pulse(32'd1);
            pulse(32'(200000 << k));
            if (k < 3) begin
                chk("ar_rearm", cnt_rst_n, 0);
                chk("ar_no_valid", res_valid, 0);
            end else begin
                chk("ar_valid", res_valid, 1);
                chk("ar_count", res_count, 1600000);
                chk("ar_res_ncyc", res_ncycles, 8);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
`endif

        // Random traffic, checked every cycle against the model.
        for (int unsigned i = 0; i < 6000; i++) begin
            rst          = ($urandom_range(0, 1999) != 0);
            start        = ($urandom_range(0, 19) == 0);
            stop         = ($urandom_range(0, 149) == 0);
            cnt_done     = ($urandom_range(0, 7) == 0);
            cnt_value    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 2000000));
            res_ready    = ($urandom_range(0, 2) == 0);
            ncycles_init = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) continuous = ~continuous;
            if ($urandom_range(0, 99) == 0)
                tmo_limit = ($urandom_range(0, 3) == 0) ? '0 : 32'($urandom_range(1, 40));
            tick();
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; cnt_done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
